display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for the eight-digit seven-segment display. It shares the single segment/decimal-point bus between the eight digit slots `d1`..`d8` produced by the watch block, one slot at a time. Each slot is preceded by an anti-ghosting blank interval. The block decodes each slot's 4-bit value to active-low segments and drives the active-low anode lines of the board.

## Interface

Parameters:
- `SLOT_CYCLES`, default 100000: clock cycles per digit slot (1 ms at 100 MHz, giving a 125 Hz frame rate). Must be ≥ 2.
- `BLANK_CYCLES`, default 1000: leading cycles of each slot with all anodes off. Legal range is 0 ≤ `BLANK_CYCLES` < `SLOT_CYCLES`.

Ports:
- `clk_100MHz_i`  in  1  system clock; single clock domain.
- `reset_i`  in  1  synchronous, active-high reset.
- `d1`..`d8`  in  6 each  digit slot, formatted {enable, value[3:0], dp_n}. `d1` is the rightmost digit and `d8` the leftmost.
- `an_o`  out  8  anodes, active-low; bit k drives slot d(k+1).
- `seg_o`  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp_o`  out  1  decimal point, active-low.
- `slot_o`  out  3  index of the slot currently owning the bus (0 = `d1`).
- `frame_o`  out  1  one-cycle pulse on the first cycle of slot 0, each time the index wraps from 7 to 0.

## Operation

- State:
  - `cnt`: 0..`SLOT_CYCLES`-1.
  - `idx`: 0..7.
  - `phase`: BLANK or DRIVE.
  - `lat`: 6-bit latched slot.
- BLANK phase:
  - `an_o`=8'hFF, `seg_o`=7'h7F, `dp_o`=1.
  - The phase lasts `BLANK_CYCLES` cycles; it is skipped entirely when `BLANK_CYCLES`=0.
- BLANK→DRIVE transition:
  - `d(idx+1)` is latched into `lat` on the clock edge that ends BLANK.
  - Input changes during DRIVE are ignored until the next slot.
- DRIVE phase, lasting `SLOT_CYCLES`-`BLANK_CYCLES` cycles:
  - If `lat[5]`=1: `an_o` has only bit `idx` low, `seg_o`=decode(`lat[4:1]`), `dp_o`=`lat[0]`.
  - If `lat[5]`=0: outputs stay at blank values, but slot timing is unchanged.
- End of DRIVE: `cnt`→0, `idx`→(`idx`+1) mod 8 (7 wraps to 0), `phase`→BLANK (or DRIVE directly if `BLANK_CYCLES`=0).
- Decode, active-low, {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Guarantees:
  - At most one anode is low in any cycle.
  - `an_o` never changes directly from one low anode to a different low anode; at least `BLANK_CYCLES` all-high cycles separate them when `BLANK_CYCLES`>0.
- Reset:
  - Values: `cnt`=0, `idx`=0, `phase`=BLANK, `lat`=0, `an_o`=8'hFF, `seg_o`=7'h7F, `dp_o`=1, `slot_o`=0, `frame_o`=0.
  - A reset asserted mid-slot or mid-frame aborts the scan; the first cycle after reset shows the reset values.

## Timing

- All outputs are registered and change only on `clk_100MHz_i` rising edges.
- Cycle numbering: cycle 0 is the first cycle after the edge on which `reset_i` is sampled 0.
- Slot n occupies cycles n·`SLOT_CYCLES` .. (n+1)·`SLOT_CYCLES`-1.
- Within each slot:
  - Outputs are blank for the first `BLANK_CYCLES` cycles and lit for the remainder.
  - The lit value is the input sampled in the last blank cycle, or in the last cycle of the previous slot when `BLANK_CYCLES`=0.
- Latency from an input change to a visible change is at most 8·`SLOT_CYCLES` cycles.
- `slot_o` equals `idx` and changes on the first cycle of each slot, together with the start of BLANK.
- `frame_o` is high for exactly one cycle per 8·`SLOT_CYCLES` cycles, at cycle 8k·`SLOT_CYCLES` for k ≥ 1. It does not pulse after reset.
- Frame period at default parameters: 800000 cycles (8 ms).

## Test plan

Unless noted, all scenarios run with `SLOT_CYCLES`=8 and `BLANK_CYCLES`=2.

- **Reset state:** hold reset, then release with `d1`..`d8`=6'b1_0011_1 -> cycles 0-1: `an_o`=FF, `seg_o`=7F, `dp_o`=1; cycles 2-7: `an_o`=FE, `seg_o`=0110000, `dp_o`=1; cycle 10: `an_o`=FD.
- **Full sweep:** `dN` = {1, N-1, 0} for N=1..8 -> each slot k shows decode(k) with `dp_o`=0 on anode k; `frame_o` high only at cycle 64; `slot_o` wraps 7→0 at cycle 64.
- **Disabled digit:** `d3`=6'b0_1000_1 -> cycles 16-23 are all blank, while slots 2 and 4 keep their exact cycle positions.
- **Mid-slot input change:** change `d1` from value 5 to value 8 at cycle 4 -> `seg_o` stays 0010010 through cycle 7; value 8 (0000000) first appears at cycle 66.
- **Blank/anode overlap check:** over 1000 random cycles, at most one `an_o` bit is low, and every transition between different low anodes is separated by ≥ 2 all-high cycles. Repeat with `BLANK_CYCLES`=0: no blank cycles, and the slot change is a direct one-hot shift.
- **Reset mid-operation:** assert reset at cycle 37 (slot 4, lit) -> the next cycle shows reset values; after release, slot 0 restarts at cycle 0 with no `frame_o` pulse.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scan controller: one slot per SLOT_CYCLES window,
// each slot opening with an all-off blank interval to suppress ghosting.
module display_scan_ctrl #(
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk_100MHz_i,
    input  logic       reset_i,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [2:0] slot_o,
    output logic       frame_o
);

    localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(BLANK_CYCLES);
    localparam bit HAS_BLANK = (BLANK_CYCLES != 0);

    typedef enum logic {
        BLANK,
        DRIVE
    } phase_t;

    // cnt/idx/phase describe the cycle the next clock edge will present.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx;
    phase_t           phase;
    phase_t           phase_nxt;
    logic [5:0]       lat;
    logic [5:0]       sel_slot;
    logic [5:0]       shown;
    logic             lit;
    logic             run;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        sel_slot = d1;
        case (idx)
            3'd0: sel_slot = d1;
            3'd1: sel_slot = d2;
            3'd2: sel_slot = d3;
            3'd3: sel_slot = d4;
            3'd4: sel_slot = d5;
            3'd5: sel_slot = d6;
            3'd6: sel_slot = d7;
            default: sel_slot = d8;
        endcase
    end

    // First lit cycle shows the slot sampled on the same edge that latches it.
    always_comb begin
        shown   = (cnt == CNT_LATCH) ? sel_slot : lat;
        lit     = (phase == DRIVE) && shown[5];
        cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        phase_nxt = phase;
        if (cnt_nxt == CNT_LATCH) begin
            phase_nxt = DRIVE;
        end else if (cnt_nxt == '0) begin
            phase_nxt = BLANK;
        end
    end

    always_ff @(posedge clk_100MHz_i) begin
        if (reset_i) begin
            cnt     <= '0;
            idx     <= 3'd0;
            phase   <= HAS_BLANK ? BLANK : DRIVE;
            lat     <= 6'd0;
            run     <= 1'b0;
            an_o    <= 8'hFF;
            seg_o   <= 7'h7F;
            dp_o    <= 1'b1;
            slot_o  <= 3'd0;
            frame_o <= 1'b0;
        end else begin
            run     <= 1'b1;
            slot_o  <= idx;
            frame_o <= run && (cnt == '0) && (idx == 3'd0);
            if (cnt == CNT_LATCH) begin
                lat <= sel_slot;
            end
            if (lit) begin
                an_o  <= ~(8'd1 << idx);
                seg_o <= seg_decode(shown[4:1]);
                dp_o  <= shown[0];
            end else begin
                an_o  <= 8'hFF;
                seg_o <= 7'h7F;
                dp_o  <= 1'b1;
            end
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
            if (cnt == CNT_LAST) begin
                idx <= idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: one instance with a blank interval,
// one without, both driven from the same digit inputs.
module tb_display_scan_ctrl;

    localparam int unsigned SLOT  = 8;
    localparam int unsigned BLANK = 2;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] slot;
        logic       frame;
    } exp_t;

    localparam logic [6:0] DEC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk_100MHz_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [5:0] d [8];

    logic [7:0] an_b, an_z;
    logic [6:0] seg_b, seg_z;
    logic       dp_b, dp_z;
    logic [2:0] slot_b, slot_z;
    logic       frame_b, frame_z;

    always #5 clk_100MHz_i = ~clk_100MHz_i;

    display_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut_b (
        .clk_100MHz_i(clk_100MHz_i), .reset_i(reset_i),
        .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]),
        .d5(d[4]), .d6(d[5]), .d7(d[6]), .d8(d[7]),
        .an_o(an_b), .seg_o(seg_b), .dp_o(dp_b), .slot_o(slot_b), .frame_o(frame_b)
    );

    display_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(0)) dut_z (
        .clk_100MHz_i(clk_100MHz_i), .reset_i(reset_i),
        .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]),
        .d5(d[4]), .d6(d[5]), .d7(d[6]), .d8(d[7]),
        .an_o(an_z), .seg_o(seg_z), .dp_o(dp_z), .slot_o(slot_z), .frame_o(frame_z)
    );

    exp_t       q_b [$];
    exp_t       q_z [$];
    logic [5:0] lat_b [8];
    logic [5:0] lat_z [8];
    int         n = -1;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic exp_t expect_of(int cyc, bit drive, int k, logic [5:0] l);
        exp_t e;
        logic [7:0] one;
        one     = 8'h01;
        e.slot  = 3'(k);
        e.frame = (cyc > 0) && (cyc % 64 == 0);
        if (drive && l[5]) begin
            e.an  = ~(one << k);
            e.seg = DEC[l[4:1]];
            e.dp  = l[0];
        end else begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end
        return e;
    endfunction

    // Expected outputs for cycle n, using the inputs as sampled at the edge starting it.
    task automatic push_expect();
        exp_t e;
        int pos, k;
        if (n < 0) begin
            for (int i = 0; i < 8; i++) begin
                lat_b[i] = 6'd0;
                lat_z[i] = 6'd0;
            end
            e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.slot = 3'd0; e.frame = 1'b0;
            q_b.push_back(e);
            q_z.push_back(e);
            return;
        end
        pos = n % SLOT;
        k   = (n / SLOT) % 8;
        if (pos == BLANK) lat_b[k] = d[k];
        if (pos == 0)     lat_z[k] = d[k];
        q_b.push_back(expect_of(n, pos >= BLANK, k, lat_b[k]));
        q_z.push_back(expect_of(n, 1'b1, k, lat_z[k]));
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        @(posedge clk_100MHz_i);
        #1;
        n = -1;
        push_expect();
        reset_i = 1'b0;
    endtask

    task automatic run(int cycles);
        repeat (cycles) begin
            @(posedge clk_100MHz_i);
            #1;
            n++;
            push_expect();
        end
    endtask

    task automatic set_sweep();
        for (int i = 0; i < 8; i++) d[i] = {1'b1, 4'(i), 1'b0};
    endtask

    exp_t got_b, got_z, e_b, e_z;
    int   blank_run = 0;
    int   last_low = -1;
    int   cur_low;

    // Monitor: pop one expectation per instance each cycle and check anode guarantees.
    always @(negedge clk_100MHz_i) begin
        got_b = {an_b, seg_b, dp_b, slot_b, frame_b};
        got_z = {an_z, seg_z, dp_z, slot_z, frame_z};
        if (q_b.size() > 0) begin
            e_b = q_b.pop_front();
            vectors++;
            if (got_b !== e_b) begin
                miscompares++;
                $display("FAIL scan_blank2 cycle %0d: got an=%h seg=%b dp=%b slot=%0d frame=%b, want an=%h seg=%b dp=%b slot=%0d frame=%b",
                         n, an_b, seg_b, dp_b, slot_b, frame_b, e_b.an, e_b.seg, e_b.dp, e_b.slot, e_b.frame);
            end
        end
        if (q_z.size() > 0) begin
            e_z = q_z.pop_front();
            vectors++;
            if (got_z !== e_z) begin
                miscompares++;
                $display("FAIL scan_blank0 cycle %0d: got an=%h seg=%b dp=%b slot=%0d frame=%b, want an=%h seg=%b dp=%b slot=%0d frame=%b",
                         n, an_z, seg_z, dp_z, slot_z, frame_z, e_z.an, e_z.seg, e_z.dp, e_z.slot, e_z.frame);
            end
        end
        vectors++;
        if ($countones(~an_b) > 1 || $countones(~an_z) > 1) begin
            miscompares++;
            $display("FAIL onehot_anode cycle %0d: an_blank2=%h an_blank0=%h, want at most one low bit", n, an_b, an_z);
        end
        if (an_b == 8'hFF) begin
            blank_run++;
        end else begin
            cur_low = 0;
            for (int i = 0; i < 8; i++) if (!an_b[i]) cur_low = i;
            if (last_low >= 0 && cur_low != last_low) begin
                vectors++;
                if (blank_run < int'(BLANK)) begin
                    miscompares++;
                    $display("FAIL anode_gap cycle %0d: %0d blank cycles between anode %0d and %0d, want >= %0d",
                             n, blank_run, last_low, cur_low, BLANK);
                end
            end
            last_low  = cur_low;
            blank_run = 0;
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) d[i] = 6'b1_0011_1;
        repeat (2) @(posedge clk_100MHz_i);
        #1;

        // Reset state and first two slots with value 3, dp off.
        apply_reset();
        run(12);

        // Full sweep: slot k shows digit k with dp on; frame pulse at cycle 64.
        set_sweep();
        apply_reset();
        run(72);

        // Disabled third digit keeps its slot but stays dark.
        set_sweep();
        d[2] = 6'b0_1000_1;
        apply_reset();
        run(40);

        // Mid-slot change on d1 is held off until the next visit of slot 0.
        set_sweep();
        d[0] = {1'b1, 4'd5, 1'b0};
        apply_reset();
        run(4);
        d[0] = {1'b1, 4'd8, 1'b0};
        run(68);

        // Random inputs changing every cycle.
        apply_reset();
        repeat (1000) begin
            run(1);
            for (int i = 0; i < 8; i++) d[i] = 6'($urandom);
        end

        // Reset during slot 4, then a clean restart with no early frame pulse.
        set_sweep();
        apply_reset();
        run(38);
        apply_reset();
        run(70);

        @(posedge clk_100MHz_i);
        @(negedge clk_100MHz_i);
        #1;
        vectors++;
        if (q_b.size() != 0 || q_z.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d/%0d expectations left, want 0/0", q_b.size(), q_z.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
